fp_div_iter: RTL
================

// Module: fp_div_iter
// PURPOSE
//  Parametrised iterative IEEE-754 divider for the F-extension execute stage.
//  Computes A/B with digit-recurrence mantissa division, producing QPC quotient bits per cycle.
//  Handles subnormals, all five RISC-V rounding modes, and fflags.
//  Drives out_stall to freeze the pipeline while it is busy.
// PARAMETERS
//  EXP_W  8   exponent width (8 = binary32)
//  MAN_W  23  stored fraction width
//  QPC    1   quotient bits retired per ITER cycle (1, 2 or 4)
//  Derived:
//   W     = 1+EXP_W+MAN_W
//   Q_W   = MAN_W+3 (quotient bits)
//   ITERS = ceil(Q_W/QPC)
// PORTS
//  in_Clk     in   1      clock, rising edge
//  in_Rst_N   in   1      synchronous active-low reset
//  in_start   in   1      request; sampled only in IDLE
//  in_kill    in   1      pipeline flush; aborts any operation
//  in_rm      in   3      rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM
//  in_numA    in   W      dividend; captured on the accepting edge
//  in_numB    in   W      divisor; captured on the accepting edge
//  out_stall  out  1      busy
//  out_valid  out  1      one-cycle pulse when out_result/out_flags are valid
//  out_result out  W      quotient; held until the next out_valid
//  out_flags  out  5      {NV,DZ,OF,UF,NX}; held with out_result
// BEHAVIOUR
//  Reset (in_Rst_N=0 at an edge):
//   - state=IDLE; out_stall, out_valid, out_result, out_flags all 0.
//  FSM states: IDLE, PREP, ITER, ROUND.
//   - IDLE:  in_start=1 -> capture operands and in_rm, out_stall<=1, go to PREP.
//   - PREP:  unpack; normalise subnormal mantissas with a leading-zero count; exp = eA-eB+bias.
//            Special operand -> load the special result and go to ROUND.
//            Otherwise go to ITER with iteration counter=0.
//   - ITER:  restoring recurrence, QPC bits per cycle.
//            After ITERS cycles go to ROUND; surplus bits fold into sticky.
//   - ROUND: normalise the quotient (1 bit left shift if <1).
//            Denormalise if the biased exponent is <=0; sticky = remainder!=0.
//            Round per rm, then register out_result and out_flags.
//            out_valid<=1, out_stall<=0, go to IDLE.
//  Latency, counted from the accepting edge:
//   - normal operands: out_valid is high after edge ITERS+2 (28 for the defaults).
//   - special operands: out_valid is high after edge 2.
//  Busy and kill rules:
//   - in_start while busy is ignored; the caller holds its instruction on out_stall.
//   - in_kill=1 in any non-IDLE state: next edge -> IDLE, out_stall=0, no out_valid.
//     out_result and out_flags keep their old values.
//   - in_kill has priority over in_start in IDLE.
//   - A new start may be accepted in the cycle out_valid is high (back-to-back).
//  Special cases (sign = sA^sB unless the result is NaN):
//   - any NaN -> canonical 0x7FC00000; NV only if an input is an sNaN.
//   - 0/0, inf/inf -> canonical NaN, NV.
//   - finite nonzero/0 -> inf, DZ.
//   - inf/finite -> inf; finite/inf -> signed 0; 0/nonzero finite -> signed 0; no flags.
//  Overflow (rounded exponent >= all-ones): OF|NX.
//   - RNE, RMM -> inf.
//   - RTZ -> max finite.
//   - RDN: + gives max finite, - gives -inf.
//   - RUP: + gives +inf, - gives -max finite.
//  Underflow: UF when the result is tiny after rounding (unbounded exponent) and inexact.
//  NX whenever any discarded bit (guard, round or sticky) is nonzero.
//  Invalid rm codes (101-111) behave as RNE; they are trapped upstream.
// TESTING
//  1. 0x3F800000/0x40400000 rm=RNE -> 0x3EAAAAAB, flags=NX (00001); rm=RTZ -> 0x3EAAAAAA.
//  2. 0x40C00000/0x40000000 -> 0x40400000, flags 0; out_valid exactly 28 edges after start, one cycle wide.
//  3. 1.0/0.0 -> 0x7F800000 DZ; 0/0 -> 0x7FC00000 NV; 0x7FA00000/1.0 -> 0x7FC00000 NV; each valid after 2 edges.
//  4. 0x7F7FFFFF/0x3F000000: RNE -> 0x7F800000, OF|NX; RTZ -> 0x7F7FFFFF, OF|NX.
//  5. 0x00800000/0x40000000 -> 0x00400000, flags 0; 0x00000001/0x40000000 RNE -> 0x00000000, UF|NX.
//  6. in_kill at edge 10 of an operation -> IDLE next edge, no out_valid; new start runs normally.
//     Reset mid-ITER -> all outputs 0.

Source files
------------

// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 divider: restoring recurrence retiring QPC quotient bits per cycle,
// with subnormal operands and results, RISC-V rounding modes and fflags.
module fp_div_iter #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int QPC   = 1
) (
   input  logic                 in_Clk,
   input  logic                 in_Rst_N,
   input  logic                 in_start,
   input  logic                 in_kill,
   input  logic [2:0]           in_rm,
   input  logic [EXP_W+MAN_W:0] in_numA,
   input  logic [EXP_W+MAN_W:0] in_numB,
   output logic                 out_stall,
   output logic                 out_valid,
   output logic [EXP_W+MAN_W:0] out_result,
   output logic [4:0]           out_flags
);
   // state | meaning
   // IDLE  | waiting for in_start
   // PREP  | unpack, normalise subnormals, detect special operands
   // ITER  | restoring recurrence, QPC quotient bits per cycle
   // ROUND | normalise, denormalise, round, register result and flags

   localparam int W       = 1 + EXP_W + MAN_W;
   localparam int Q_W     = MAN_W + 3;
   localparam int ITERS   = (Q_W + QPC - 1) / QPC;
   localparam int QT_W    = ITERS * QPC;
   localparam int XW      = EXP_W + 3;
   localparam int R_W     = MAN_W + 3;
   localparam int LZ_W    = $clog2(MAN_W + 2);
   localparam int CNT_W   = $clog2(ITERS + 1);
   localparam int BIAS    = (1 << (EXP_W - 1)) - 1;
   localparam int EXP_MAX = (1 << EXP_W) - 1;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   function automatic logic [LZ_W-1:0] lzc_f(input logic [MAN_W:0] m);
      lzc_f = '0;
      for (int i = 0; i <= MAN_W; i++)
         if (m[i]) lzc_f = LZ_W'(MAN_W - i);
   endfunction

   function automatic logic rnd_inc_f(input logic [2:0] rm, input logic s, input logic lsb,
                                      input logic g, input logic rs);
      case (rm)
         RM_RTZ:  rnd_inc_f = 1'b0;
         RM_RDN:  rnd_inc_f = s & (g | rs);
         RM_RUP:  rnd_inc_f = ~s & (g | rs);
         RM_RMM:  rnd_inc_f = g;
         default: rnd_inc_f = g & (rs | lsb);
      endcase
   endfunction

   typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_ROUND} state_t;

   state_t               state_q, state_d;
   logic [W-1:0]         a_q, a_d, b_q, b_d;
   logic [2:0]           rm_q, rm_d;
   logic                 sign_q, sign_d;
   logic signed [XW-1:0] exp_q, exp_d;
   logic [R_W-1:0]       rem_q, rem_d;
   logic [MAN_W:0]       div_q, div_d;
   logic [QT_W-1:0]      quo_q, quo_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 spec_q, spec_d;
   logic [W-1:0]         spec_res_q, spec_res_d;
   logic [4:0]           spec_fl_q, spec_fl_d;
   logic [W-1:0]         result_q, result_d;
   logic [4:0]           flags_q, flags_d;
   logic                 valid_q, valid_d;

   logic [EXP_W-1:0]     ea_raw, eb_raw;
   logic [MAN_W-1:0]     fa, fb;
   logic [MAN_W:0]       ma, mb, ma_n, mb_n;
   logic [LZ_W-1:0]      lz_a, lz_b;
   logic signed [XW-1:0] ea, eb;
   logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, sgn;

   assign ea_raw = a_q[W-2 -: EXP_W];
   assign eb_raw = b_q[W-2 -: EXP_W];
   assign fa     = a_q[MAN_W-1:0];
   assign fb     = b_q[MAN_W-1:0];
   assign sgn    = a_q[W-1] ^ b_q[W-1];
   assign a_zero = (ea_raw == '0) && (fa == '0);
   assign b_zero = (eb_raw == '0) && (fb == '0);
   assign a_inf  = (&ea_raw) && (fa == '0);
   assign b_inf  = (&eb_raw) && (fb == '0);
   assign a_nan  = (&ea_raw) && (fa != '0);
   assign b_nan  = (&eb_raw) && (fb != '0);
   assign a_snan = a_nan & ~fa[MAN_W-1];
   assign b_snan = b_nan & ~fb[MAN_W-1];
   assign ma     = {|ea_raw, fa};
   assign mb     = {|eb_raw, fb};
   assign lz_a   = lzc_f(ma);
   assign lz_b   = lzc_f(mb);
   assign ma_n   = ma << lz_a;
   assign mb_n   = mb << lz_b;
   // Subnormals get exponent 1 minus the shift that normalised them
   assign ea     = (ea_raw == '0) ? XW'(1) - XW'(lz_a) : XW'(ea_raw);
   assign eb     = (eb_raw == '0) ? XW'(1) - XW'(lz_b) : XW'(eb_raw);

   logic         special;
   logic [W-1:0] spec_res;
   logic [4:0]   spec_fl;

   always_comb begin
      special  = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
      spec_res = {sgn, {(W-1){1'b0}}};
      spec_fl  = '0;
      if (a_nan | b_nan) begin
         spec_res = QNAN;
         spec_fl  = {a_snan | b_snan, 4'b0000};
      end else if ((a_zero & b_zero) | (a_inf & b_inf)) begin
         spec_res = QNAN;
         spec_fl  = 5'b10000;
      end else if (a_inf) begin
         spec_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (b_zero) begin
         spec_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         spec_fl  = 5'b01000;
      end
   end

   logic [R_W-1:0]  rem_it;
   logic [QT_W-1:0] quo_it;

   always_comb begin
      rem_it = rem_q;
      quo_it = quo_q;
      for (int k = 0; k < QPC; k++) begin
         if (rem_it >= R_W'(div_q)) begin
            rem_it = rem_it - R_W'(div_q);
            quo_it = {quo_it[QT_W-2:0], 1'b1};
         end else begin
            quo_it = {quo_it[QT_W-2:0], 1'b0};
         end
         rem_it = rem_it << 1;
      end
   end

   logic [Q_W-1:0]       q_top, ext;
   logic [MAN_W:0]       sig;
   logic                 surplus, sticky0, sticky, g_b, r_b, rs, inexact, inc, inc_n;
   logic                 tiny, ovf, to_inf;
   logic signed [XW-1:0] exp_r, sh;
   logic [EXP_W-1:0]     e_field;
   logic [W-1:0]         sum, rnd_res;
   logic [4:0]           rnd_fl;

   always_comb begin
      q_top   = quo_q[QT_W-1 -: Q_W];
      surplus = 1'b0;
      for (int i = 0; i < QT_W - Q_W; i++) surplus = surplus | quo_q[i];
      sticky0 = (|rem_q) | surplus;
      // A quotient below 1 has one fewer bit of precision; the missing round bit
      // is implied by a nonzero remainder, so guard plus sticky still rounds exactly
      if (q_top[Q_W-1]) begin
         sig   = q_top[Q_W-1:2];
         g_b   = q_top[1];
         r_b   = q_top[0];
         exp_r = exp_q;
      end else begin
         sig   = q_top[Q_W-2:1];
         g_b   = q_top[0];
         r_b   = 1'b0;
         exp_r = exp_q - XW'(1);
      end
      inc_n   = rnd_inc_f(rm_q, sign_q, sig[0], g_b, r_b | sticky0);
      tiny    = (int'(exp_r) < 0) || ((int'(exp_r) == 0) && !((&sig) && inc_n));
      ext     = {sig, g_b, r_b};
      sticky  = sticky0;
      e_field = exp_r[EXP_W-1:0];
      sh      = '0;
      if (int'(exp_r) <= 0) begin
         sh = XW'(1) - exp_r;
         for (int i = 0; i < Q_W; i++)
            if (XW'(i) < sh) sticky = sticky | ext[i];
         ext     = ext >> sh;
         e_field = '0;
      end
      rs      = ext[0] | sticky;
      inexact = ext[1] | rs;
      inc     = rnd_inc_f(rm_q, sign_q, ext[2], ext[1], rs);
      // A carry out of the fraction bumps the exponent, including subnormal to normal
      sum     = {1'b0, e_field, ext[Q_W-2:2]} + W'(inc);
      ovf     = (int'(exp_r) >= EXP_MAX) || (&sum[W-2 -: EXP_W]) || sum[W-1];
      case (rm_q)
         RM_RTZ:  to_inf = 1'b0;
         RM_RDN:  to_inf = sign_q;
         RM_RUP:  to_inf = ~sign_q;
         default: to_inf = 1'b1;
      endcase
      if (ovf) begin
         rnd_res = to_inf ? {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                          : {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
         rnd_fl  = 5'b00101;
      end else begin
         rnd_res = {sign_q, sum[W-2:0]};
         rnd_fl  = {3'b000, tiny & inexact & (int'(exp_r) <= 0), inexact};
      end
   end

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      rm_d       = rm_q;
      sign_d     = sign_q;
      exp_d      = exp_q;
      rem_d      = rem_q;
      div_d      = div_q;
      quo_d      = quo_q;
      cnt_d      = cnt_q;
      spec_d     = spec_q;
      spec_res_d = spec_res_q;
      spec_fl_d  = spec_fl_q;
      result_d   = result_q;
      flags_d    = flags_q;
      valid_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_start && !in_kill) begin
               a_d     = in_numA;
               b_d     = in_numB;
               rm_d    = in_rm;
               state_d = S_PREP;
            end
         end
         S_PREP: begin
            sign_d     = sgn;
            exp_d      = ea - eb + XW'(BIAS);
            rem_d      = R_W'(ma_n);
            div_d      = mb_n;
            quo_d      = '0;
            cnt_d      = '0;
            spec_d     = special;
            spec_res_d = spec_res;
            spec_fl_d  = spec_fl;
            state_d    = special ? S_ROUND : S_ITER;
         end
         S_ITER: begin
            rem_d = rem_it;
            quo_d = quo_it;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ITERS - 1)) state_d = S_ROUND;
         end
         S_ROUND: begin
            result_d = spec_q ? spec_res_q : rnd_res;
            flags_d  = spec_q ? spec_fl_q : rnd_fl;
            valid_d  = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (in_kill && (state_q != S_IDLE)) begin
         state_d  = S_IDLE;
         valid_d  = 1'b0;
         result_d = result_q;
         flags_d  = flags_q;
      end
   end

   always_ff @(posedge in_Clk) begin
      if (!in_Rst_N) begin
         state_q    <= S_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         rm_q       <= '0;
         sign_q     <= 1'b0;
         exp_q      <= '0;
         rem_q      <= '0;
         div_q      <= '0;
         quo_q      <= '0;
         cnt_q      <= '0;
         spec_q     <= 1'b0;
         spec_res_q <= '0;
         spec_fl_q  <= '0;
         result_q   <= '0;
         flags_q    <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         rm_q       <= rm_d;
         sign_q     <= sign_d;
         exp_q      <= exp_d;
         rem_q      <= rem_d;
         div_q      <= div_d;
         quo_q      <= quo_d;
         cnt_q      <= cnt_d;
         spec_q     <= spec_d;
         spec_res_q <= spec_res_d;
         spec_fl_q  <= spec_fl_d;
         result_q   <= result_d;
         flags_q    <= flags_d;
         valid_q    <= valid_d;
      end
   end

   assign out_stall  = (state_q != S_IDLE);
   assign out_valid  = valid_q;
   assign out_result = result_q;
   assign out_flags  = flags_q;

endmodule
